mdu_seq: RTL

- Multi-cycle RV32M multiply/divide sequencer that drives the core's shared 32-bit ALU, so no dedicated adder is needed.
- Accepts one MUL/DIV/REM operation at a time and runs 32 shift-add or shift-subtract iterations.
- In each iteration it issues `ALU_ADD` or `ALU_SUB` to the ALU and consumes `result` plus the C flag.
- Sits beside the execute stage. The pipeline stalls on `busy` and the ALU input mux selects the sequencer while `busy`=1.

---
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - RV32M multiply/divide sequencer over the shared ALU; optional early out via MDU_EARLY_OUT_EN
`ifndef ALU_ADD
`define ALU_ADD 5'b00000
`endif
`ifndef ALU_SUB
`define ALU_SUB 5'b00001
`endif

module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_c
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3_q;
    logic [XLEN-1:0]     hi_q, lo_q, mcand_q, opa_q;
    logic                neg_q, neg_rem_q, bzero_q, ovf_q, mzero_q;

    logic                a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b, t;
    logic                ovf_in, mzero_in, early_in;
    logic [2*XLEN-1:0]   prod, prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, fin_result;

    // Operand decode: MUL's low half is sign-agnostic, so it is treated as unsigned
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'd2:             a_sgn = 1'b1;
            default:          ;
        endcase
    end

    assign sa       = a_sgn & op_a[XLEN-1];
    assign sb       = b_sgn & op_b[XLEN-1];
    assign mag_a    = sa ? (~op_a + 1'b1) : op_a;
    assign mag_b    = sb ? (~op_b + 1'b1) : op_b;
    assign ovf_in   = (funct3 == 3'd4 || funct3 == 3'd6) && op_a == MIN_NEG && op_b == '1;
    assign mzero_in = ~funct3[2] && (op_a == '0 || op_b == '0);
    assign early_in = (funct3[2] && op_b == '0) || ovf_in || mzero_in;

    // Partial remainder shifted left with the next dividend bit
    assign t = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef MDU_EARLY_OUT_EN
                state_nxt = early_in ? S_FIN : S_ITER;
`else
                state_nxt = S_ITER;
`endif
            end
            S_ITER: if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        alu_ctrl = `ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        if (state == S_ITER) begin
            if (f3_q[2]) begin
                alu_ctrl = `ALU_SUB;
                alu_a    = t;
            end else begin
                alu_a    = hi_q;
            end
            alu_b = mcand_q;
        end
    end

    // Sign correction and RISC-V special-case overrides
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        quo_s  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_s  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
        case (f3_q)
            3'd0:             fin_result = mzero_q ? '0 : prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin_result = mzero_q ? '0 : prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fin_result = bzero_q ? '1 : (ovf_q ? MIN_NEG : quo_s);
            default:          fin_result = bzero_q ? opa_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            f3_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            opa_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            mzero_q   <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_FIN);
            case (state)
                S_IDLE: if (start) begin
                    f3_q      <= funct3;
                    opa_q     <= op_a;
                    hi_q      <= '0;
                    lo_q      <= funct3[2] ? mag_a : mag_b;
                    mcand_q   <= funct3[2] ? mag_b : mag_a;
                    neg_q     <= sa ^ sb;
                    neg_rem_q <= sa;
                    bzero_q   <= (op_b == '0);
                    ovf_q     <= ovf_in;
                    mzero_q   <= mzero_in;
                    cnt       <= '0;
                end
                S_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (f3_q[2]) begin
                        if (hi_q[XLEN-1] || !alu_c) begin
                            hi_q <= alu_result;
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= t;
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else if (lo_q[0]) begin
                        {hi_q, lo_q} <= {alu_c, alu_result, lo_q[XLEN-1:1]};
                    end else begin
                        {hi_q, lo_q} <= {1'b0, hi_q, lo_q[XLEN-1:1]};
                    end
                end
                S_FIN: result <= fin_result;
                default: ;
            endcase
        end
    end

endmodule
